ps2_kbd_ctrl: RTL

Protocol controller that sits between the PS/2 frame receiver (bytes already deserialised and parity/start/stop checked) and the display/CPU consumers. It sequences the scancode set-2 prefix protocol (E0 extended, F0 break) and converts raw bytes into complete key events. Events are buffered in a small FIFO with a valid/ready consumer handshake. It also maintains release, held-key and error status for the seven-segment status display.

---
 rtl/ps2_kbd_ctrl_if.sv | 14 +
 rtl/ps2_kbd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-in / key-event-out handshake bundle for ps2_kbd_ctrl.
interface ps2_kbd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;

    modport master (output rx_valid, rx_data, rx_err, evt_ready,
                    input  evt_valid, evt_data);
    modport slave  (input  rx_valid, rx_data, rx_err, evt_ready,
                    output evt_valid, evt_data);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Scancode set-2 prefix sequencer (E0/F0) turning PS/2 bytes into buffered key events + status.
// Latency: event visible on evt_valid one cycle after its final byte; FWFT FIFO, pop on valid&&ready.
// Backpressure: full FIFO drops new events (sticky overflow); PS2_REPEAT_FILTER_EN suppresses typematic repeats.

// Generic first-word-fall-through FIFO; head reads as zero while empty.
// Latency: 1 cycle push-to-head; push while full is ignored unless a pop happens in the same cycle.
// Backpressure: caller observes full and decides drop policy.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the write lands in when full (wr_ptr == rd_ptr).
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ps2_kbd_ctrl_if.slave                 bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [7:0]                    release_cnt,
    output logic                          held_valid,
    output logic [8:0]                    held_code,
    output logic [7:0]                    err_cnt
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    rel_q, rel_d;
    logic          held_v_q, held_v_d;
    logic [8:0]    held_c_q, held_c_d;
    logic          ovf_q, ovf_d;

    logic          err_inc, emit, emit_ext, emit_rel;
    logic          is_e0, is_f0, is_repeat;
    logic [8:0]    evt_key;
    logic          push, pop, ovf_set;
    logic          fifo_full, fifo_empty;
    logic [9:0]    fifo_dout;

    assign is_e0   = (bus.rx_data == 8'hE0);
    assign is_f0   = (bus.rx_data == 8'hF0);
    assign evt_key = {emit_ext, bus.rx_data};

    // Prefix sequencing and inactivity timeout.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        err_inc  = 1'b0;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (bus.rx_valid) begin
            tmo_d = '0;
            if (bus.rx_err || bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) begin
                err_inc = 1'b1;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_e0)      state_d = ST_EXT;
                        else if (is_f0) state_d = ST_BRK;
                        else            emit    = 1'b1;
                    end
                    ST_EXT: begin
                        if (is_f0)      state_d = ST_EXT_BRK;
                        else if (is_e0) state_d = ST_EXT;
                        else begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        if (is_e0 || is_f0) begin
                            err_inc = 1'b1;
                        end else begin
                            emit     = 1'b1;
                            emit_rel = 1'b1;
                            emit_ext = (state_q == ST_EXT_BRK);
                        end
                    end
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                err_inc = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    assign is_repeat = held_v_q && (evt_key == held_c_q);
`else
    assign is_repeat = 1'b0;
`endif

    assign pop = !fifo_empty && bus.evt_ready;

    // Event side effects: status is tracked even when the FIFO drops the event.
    always_comb begin
        rel_d    = rel_q;
        held_v_d = held_v_q;
        held_c_d = held_c_q;
        push     = 1'b0;
        if (emit) begin
            if (emit_rel) begin
                rel_d = rel_q + 8'd1;
                push  = 1'b1;
                if (evt_key == held_c_q) held_v_d = 1'b0;
            end else if (!is_repeat) begin
                held_c_d = evt_key;
                held_v_d = 1'b1;
                push     = 1'b1;
            end
        end
        ovf_set = push && fifo_full && !pop;
        ovf_d   = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        err_d   = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    ps2_evt_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({emit_ext, emit_rel, bus.rx_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            err_q    <= '0;
            rel_q    <= '0;
            held_v_q <= 1'b0;
            held_c_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            rel_q    <= rel_d;
            held_v_q <= held_v_d;
            held_c_q <= held_c_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.evt_valid = !fifo_empty;
    assign bus.evt_data  = fifo_dout;
    assign overflow      = ovf_q;
    assign release_cnt   = rel_q;
    assign held_valid    = held_v_q;
    assign held_code     = held_c_q;
    assign err_cnt       = err_q;
endmodule
